mem_channel_arbiter: RTL
========================

MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of requesters sharing one channel (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports consumer_read_valid / consumer_write_valid  input  [NUM_CONSUMERS]  per-consumer request strobes.
REQ-007 SHALL have ports consumer_read_address / consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  request addresses.
REQ-008 SHALL have port consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write payloads.
REQ-009 SHALL have ports consumer_read_ready / consumer_write_ready  output  [NUM_CONSUMERS]  per-consumer completion.
REQ-010 SHALL have port consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  per-consumer returned data.
REQ-011 SHALL have memory-side ports mem_read_valid (out 1), mem_read_address (out ADDR_BITS), mem_read_ready (in 1), mem_read_data (in DATA_BITS), mem_write_valid (out 1), mem_write_address (out ADDR_BITS), mem_write_data (out DATA_BITS), mem_write_ready (in 1), matching the shared memory-channel bundle.

Function
REQ-012 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT, RELAY; all outputs registered.
REQ-013 IDLE: grant the first consumer at or after rr_ptr (wrapping) with read or write valid; read wins if a consumer asserts both.
REQ-014 On grant, SHALL at next edge drive mem_*_valid=1 with the granted address (and data for write), store grant index, enter READ_WAIT/WRITE_WAIT.
REQ-015 In *_WAIT, mem valid, address and data SHALL remain stable until mem_*_ready=1 is sampled.
REQ-016 On sampled mem_read_ready: next edge mem_read_valid=0, consumer_read_data[g]=mem_read_data, consumer_read_ready[g]=1, enter RELAY; write analogous (no data).
REQ-017 RELAY: hold consumer ready until that consumer's matching valid is sampled 0; next edge ready=0, rr_ptr=(g+1) mod NUM_CONSUMERS, enter IDLE.
REQ-018 At most one outstanding memory transaction; non-granted consumers SHALL see ready=0.
REQ-019 consumer_read_data[g] SHALL hold its value until overwritten by that consumer's next read.
REQ-020 Minimum request-to-ready latency: 2 cycles plus memory latency; back-to-back grants separated by >=1 IDLE cycle.
REQ-021 rr_ptr wrap: NUM_CONSUMERS-1 -> 0; a consumer requesting continuously SHALL NOT block others beyond one transaction.

Reset
REQ-022 reset_n=0 SHALL immediately force state=IDLE, rr_ptr=0, all valid/ready outputs 0, all address/data outputs 0.
REQ-023 Reset mid-transaction SHALL abandon the outstanding memory request; a mem_*_ready arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-024 FSM state enum SHALL live in the shared package as arb_state_t; address/data widths in the package as defaults.
REQ-025 A round-robin priority picker sub-module rr_picker (request vector + pointer -> one-hot grant, valid) is natural and SHALL be used.

Verification
REQ-026 Single read: consumer 1 reads 0x12, memory returns 0xBEEF after 3 cycles -> consumer_read_ready[1]=1 with data 0xBEEF, then deasserts after valid drops.
REQ-027 Single write: consumer 2 writes 0xA5A5 to 0x40 -> mem_write_address=0x40, mem_write_data=0xA5A5 stable until ready; consumer_write_ready[2] pulses via RELAY.
REQ-028 Contention: all 4 consumers read simultaneously, rr_ptr=0 -> service order 0,1,2,3; then consumer 0 again with rr_ptr=1 and 3 requesting -> 3 served before 0? no: order 3 then 0.
REQ-029 Wrap: rr_ptr=3, consumers 0 and 3 request -> 3 first, then 0; rr_ptr ends at 1.
REQ-030 Reset during READ_WAIT: reset_n low -> mem_read_valid=0 same cycle; stray mem_read_ready after release produces no consumer ready.
REQ-031 Read+write same consumer: consumer 0 asserts both -> read completes first, write next grant.

Source files
------------

// File: rtl/mem_channel_arbiter_pkg.sv
// rtl/mem_channel_arbiter_pkg.sv - shared types and default widths for the memory channel arbiter
package mem_channel_arbiter_pkg;

  localparam int DEFAULT_ADDR_BITS     = 8;
  localparam int DEFAULT_DATA_BITS     = 16;
  localparam int DEFAULT_NUM_CONSUMERS = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_channel_arbiter_rr_picker.sv
// rtl/mem_channel_arbiter_rr_picker.sv - round-robin picker: one-hot grant to the first requester at or after ptr
module rr_picker #(
  parameter int WIDTH = 4,
  parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [WIDTH-1:0] grant,
  output logic             valid
);

  int            idx;
  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    pos   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // walk from ptr upward, wrapping past the top requester
      idx = int'(ptr) + i;
      if (idx >= WIDTH) idx = idx - WIDTH;
      pos = idx[PW-1:0];
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_channel_arbiter.sv
// rtl/mem_channel_arbiter.sv - shares one memory read/write channel among consumers, one transaction at a time
module mem_channel_arbiter
  import mem_channel_arbiter_pkg::*;
#(
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS = DEFAULT_NUM_CONSUMERS
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  output logic                                  mem_read_valid,
  output logic [ADDR_BITS-1:0]                  mem_read_address,
  input  logic                                  mem_read_ready,
  input  logic [DATA_BITS-1:0]                  mem_read_data,
  output logic                                  mem_write_valid,
  output logic [ADDR_BITS-1:0]                  mem_write_address,
  output logic [DATA_BITS-1:0]                  mem_write_data,
  input  logic                                  mem_write_ready
);

  localparam int PW = $clog2(NUM_CONSUMERS);

  arb_state_t                                  state, state_next;
  logic [PW-1:0]                               rr_ptr, rr_ptr_next;
  logic [PW-1:0]                               grant_idx, grant_idx_next, pick_idx;
  logic                                        relay_read, relay_read_next, relay_done;
  logic [NUM_CONSUMERS-1:0]                    pick_onehot;
  logic                                        pick_valid;
  logic                                        mem_read_valid_next, mem_write_valid_next;
  logic [ADDR_BITS-1:0]                        mem_read_address_next, mem_write_address_next;
  logic [DATA_BITS-1:0]                        mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]                    consumer_read_ready_next, consumer_write_ready_next;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_read_data_next;

  rr_picker #(.WIDTH(NUM_CONSUMERS), .PW(PW)) u_rr_picker (
    .req   (consumer_read_valid | consumer_write_valid),
    .ptr   (rr_ptr),
    .grant (pick_onehot),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++)
      if (pick_onehot[i]) pick_idx = PW'(i);
  end

  // the granted consumer releases the channel by dropping the valid of the kind it was served
  assign relay_done = relay_read ? !consumer_read_valid[grant_idx] : !consumer_write_valid[grant_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_idx            <= '0;
      relay_read           <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state                <= state_next;
      rr_ptr               <= rr_ptr_next;
      grant_idx            <= grant_idx_next;
      relay_read           <= relay_read_next;
      mem_read_valid       <= mem_read_valid_next;
      mem_read_address     <= mem_read_address_next;
      mem_write_valid      <= mem_write_valid_next;
      mem_write_address    <= mem_write_address_next;
      mem_write_data       <= mem_write_data_next;
      consumer_read_ready  <= consumer_read_ready_next;
      consumer_write_ready <= consumer_write_ready_next;
      consumer_read_data   <= consumer_read_data_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (pick_valid) state_next = consumer_read_valid[pick_idx] ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:  if (mem_read_ready) state_next = RELAY;
      WRITE_WAIT: if (mem_write_ready) state_next = RELAY;
      RELAY:      if (relay_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_next               = rr_ptr;
    grant_idx_next            = grant_idx;
    relay_read_next           = relay_read;
    mem_read_valid_next       = mem_read_valid;
    mem_read_address_next     = mem_read_address;
    mem_write_valid_next      = mem_write_valid;
    mem_write_address_next    = mem_write_address;
    mem_write_data_next       = mem_write_data;
    consumer_read_ready_next  = consumer_read_ready;
    consumer_write_ready_next = consumer_write_ready;
    consumer_read_data_next   = consumer_read_data;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_idx_next = pick_idx;
          if (consumer_read_valid[pick_idx]) begin
            relay_read_next       = 1'b1;
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = consumer_read_address[pick_idx];
          end else begin
            relay_read_next        = 1'b0;
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = consumer_write_address[pick_idx];
            mem_write_data_next    = consumer_write_data[pick_idx];
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_next                = 1'b0;
          consumer_read_data_next[grant_idx] = mem_read_data;
          consumer_read_ready_next[grant_idx] = 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_next                 = 1'b0;
          consumer_write_ready_next[grant_idx] = 1'b1;
        end
      end
      RELAY: begin
        if (relay_done) begin
          consumer_read_ready_next  = '0;
          consumer_write_ready_next = '0;
          rr_ptr_next = (grant_idx == PW'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
